// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one single-precision multiplier among four requesters.
// One operation is in flight at a time: grant, compute, then hold the result until it is taken.
module fp_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_result,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    // state  | meaning
    // S_IDLE | waiting for a request; round-robin grant is offered
    // S_CALC | operands latched; product lands in the result register
    // S_HOLD | result presented until the consumer accepts it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       rr_ptr;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [1:0]       op_id;
    logic [31:0]      result_q;

    logic [1:0]       scan_idx;
    logic [1:0]       grant_id;
    logic             grant_hit;
    logic [NREQ-1:0]  grant;
    logic             accept;

    // First valid requester at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = rr_ptr + k[1:0];
            if (!grant_hit && req_valid[scan_idx]) begin
                grant_hit = 1'b1;
                grant_id  = scan_idx;
            end
        end
        grant = grant_hit ? (NREQ'(1) << grant_id) : '0;
    end

    assign accept = (state == S_IDLE) && grant_hit;

    // Multiplier datapath on the latched operands
    logic         sgn;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [47:0]  ma, mb, prod;
    logic signed [9:0] exp_raw, exp_norm;
    logic [22:0]  mant;
    logic [31:0]  mul_result;
    logic         unused_prod_bits;

    always_comb begin
        sgn      = op_a[31] ^ op_b[31];
        ea       = op_a[30:23];
        eb       = op_b[30:23];
        fa       = op_a[22:0];
        fb       = op_b[22:0];
        ma       = {24'd0, 1'b1, fa};
        mb       = {24'd0, 1'b1, fb};
        prod     = ma * mb;
        exp_raw  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        exp_norm = prod[47] ? (exp_raw + 10'sd1) : exp_raw;
        mant     = prod[47] ? prod[46:24] : prod[45:23];

        if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) begin
            mul_result = 32'h7FC0_0000;
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            mul_result = {sgn, 8'hFF, 23'd0};
        end else if (ea == 8'h00 || eb == 8'h00) begin
            mul_result = 32'h0000_0000;
        end else if (exp_norm < 10'sd1) begin
            mul_result = 32'h0000_0000;
        end else if (exp_norm > 10'sd254) begin
            mul_result = {sgn, 8'hFF, 23'd0};
        end else begin
            mul_result = {sgn, exp_norm[7:0], mant};
        end
    end

    // Truncation discards the low product bits by design.
    assign unused_prod_bits = ^prod[22:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_hit) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_HOLD;
            S_HOLD:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= 2'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            op_id    <= 2'd0;
            result_q <= 32'd0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[{grant_id, 5'b0} +: 32];
                op_b   <= req_b[{grant_id, 5'b0} +: 32];
                op_id  <= grant_id;
                rr_ptr <= grant_id + 2'd1;
            end
            if (state == S_CALC) begin
                result_q <= mul_result;
            end
            if (state == S_HOLD && rsp_ready) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

    // Outputs are forced quiet whenever reset is asserted, even before the first reset edge.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = 1'b0;
        rsp_id     = 2'd0;
        rsp_result = 32'd0;
        busy       = 1'b0;
        if (rst_n) begin
            req_ready  = (state == S_IDLE) ? grant : '0;
            rsp_valid  = (state == S_HOLD);
            rsp_id     = op_id;
            rsp_result = result_q;
            busy       = (state != S_IDLE);
        end
    end

endmodule
